// File: rtl/ysyx_imem_resp_pkg.sv
// Shared bus FSM encodings and read-response codes for the instruction memory responder.
// Optional feature macro used by the design: YSYX_IMEM_RAND_DELAY_EN.
package ysyx_imem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_t;

    localparam logic RRESP_OK    = 1'b0;
    localparam logic RRESP_FAULT = 1'b1;

    // Countdown holds LATENCY-1 (at most 14) plus up to 7 random extra cycles.
    localparam int unsigned CNT_W = 5;

    function automatic logic [CNT_W-1:0] lat_count(input int unsigned latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/ysyx_imem_resp_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with 8'hA5, advancing every cycle.
// Only instantiated when YSYX_IMEM_RAND_DELAY_EN is defined.
module ysyx_lfsr8 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [2:0] o_rnd3
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign o_rnd3 = r_lfsr[2:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

endmodule

// File: rtl/ysyx_imem_resp.sv
// Instruction memory responder: single outstanding read, fixed LATENCY, preload port.
// Macro YSYX_IMEM_RAND_DELAY_EN adds 0..7 LFSR-driven extra wait cycles per request.
module ysyx_imem_resp
    import ysyx_imem_resp_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned       LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arvalid,
    input  logic [ADDR_W-1:0]     araddr,
    output logic                  arready,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rresp,
    input  logic                  ld_valid,
    input  logic [DEPTH_LOG2-1:0] ld_idx,
    input  logic [DATA_W-1:0]     ld_data
);

    localparam logic [CNT_W-1:0] LAT_CNT = lat_count(LATENCY);
    localparam int unsigned      WORD_W  = ADDR_W - 2;

    bus_state_t             r_state;
    logic [ADDR_W-1:0]      r_addr;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_mem [2**DEPTH_LOG2];

    logic [CNT_W-1:0]       w_extra;
    logic [CNT_W-1:0]       w_load;
    logic [ADDR_W-1:0]      w_addr;
    logic [WORD_W-1:0]      w_word;
    logic [DEPTH_LOG2-1:0]  w_idx;
    logic                   w_fault;
    logic                   w_enter_resp;

`ifdef YSYX_IMEM_RAND_DELAY_EN
    logic [2:0] w_rnd3;

    ysyx_lfsr8 u_lfsr (
        .i_clk   (clk),
        .i_rst_n (rst),
        .o_rnd3  (w_rnd3)
    );

    assign w_extra = CNT_W'(w_rnd3);
`else
    assign w_extra = '0;
`endif

    assign arready = (r_state == IDLE);
    assign w_load  = LAT_CNT + w_extra;

    // IDLE->RESP latches and reads in the same edge, so take the address from the port.
    assign w_addr  = (r_state == IDLE) ? araddr : r_addr;
    assign w_word  = w_addr[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
    assign w_idx   = w_word[DEPTH_LOG2-1:0];
    assign w_fault = (w_addr[1:0] != 2'b00) || (w_addr < BASE_ADDR) ||
                     (w_word[WORD_W-1:DEPTH_LOG2] != '0);

    assign w_enter_resp = ((r_state == IDLE) && arvalid && (w_load == '0)) ||
                          ((r_state == WAIT) && (r_cnt == CNT_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            rvalid  <= 1'b0;
            rresp   <= RRESP_OK;
            rdata   <= '0;
        end else begin
            rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (arvalid) begin
                        r_addr  <= araddr;
                        r_cnt   <= w_load;
                        r_state <= (w_load == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // Memory read shares the edge with any preload write, so the old word is returned.
            if (w_enter_resp) begin
                rvalid <= 1'b1;
                rresp  <= w_fault ? RRESP_FAULT : RRESP_OK;
                rdata  <= w_fault ? '0 : r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_valid) begin
            r_mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_ysyx_imem_resp.sv
// Directed scoreboard bench for ysyx_imem_resp at LATENCY 1, 4 and 8.
// With YSYX_IMEM_RAND_DELAY_EN defined it runs the random-delay latency sweep instead.
module tb_ysyx_imem_resp;

    localparam int unsigned NI   = 3;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NI-1:0]        arvalid;
    logic [NI-1:0]        arready;
    logic [NI-1:0]        rvalid;
    logic [NI-1:0]        rresp;
    logic [NI-1:0][31:0]  araddr;
    logic [NI-1:0][31:0]  rdata;
    logic                 ld_valid;
    logic [11:0]          ld_idx;
    logic [31:0]          ld_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic        resp;
        int          t;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [4096];
    int          hist [8];

    ysyx_imem_resp #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .arvalid(arvalid[0]), .araddr(araddr[0]), .arready(arready[0]),
        .rvalid(rvalid[0]), .rdata(rdata[0]), .rresp(rresp[0]),
        .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data)
    );
    ysyx_imem_resp #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst), .arvalid(arvalid[1]), .araddr(araddr[1]), .arready(arready[1]),
        .rvalid(rvalid[1]), .rdata(rdata[1]), .rresp(rresp[1]),
        .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data)
    );
    ysyx_imem_resp #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .LATENCY(8)) u_lat8 (
        .clk(clk), .rst(rst), .arvalid(arvalid[2]), .araddr(araddr[2]), .arready(arready[2]),
        .rvalid(rvalid[2]), .rdata(rdata[2]), .rresp(rresp[2]),
        .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 8;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void predict(input logic [31:0] a, output logic [31:0] d, output logic r);
        logic [31:0] off;
        off = a - BASE;
        if ((a[1:0] != 2'b00) || (a < BASE) || (off >= 32'h0000_4000)) begin
            d = '0;
            r = 1'b1;
        end else begin
            d = model[off[13:2]];
            r = 1'b0;
        end
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_idx   = 12'(idx);
        ld_data  = d;
        model[idx] = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    // Drive one request (optionally with a same-cycle preload) and push its expectation.
    task automatic issue(input int i, input logic [31:0] a, input bit ld_en, input int ld_i,
                         input logic [31:0] ld_d);
        exp_t e;
        @(negedge clk);
        arvalid[i] = 1'b1;
        araddr[i]  = a;
        e.inst = i;
        e.t    = cyc;
        predict(a, e.data, e.resp);
        sb.push_back(e);
        if (ld_en) begin
            ld_valid = 1'b1;
            ld_idx   = 12'(ld_i);
            ld_data  = ld_d;
            model[ld_i] = ld_d;
        end
    endtask

    task automatic req(input int i, input logic [31:0] a);
        issue(i, a, 1'b0, 0, '0);
    endtask

    task automatic wait_resp(input int i, input string tag, input logic [31:0] scramble);
        exp_t e;
        bit   seen;
        int   d;
        seen = 1'b0;
        e = sb.pop_front();
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(arready[i]), 32'd0);
            if (rvalid[i]) begin
                seen = 1'b1;
                d    = cyc - e.t;
                chk({tag, "_data"}, rdata[i], e.data);
                chk({tag, "_resp"}, 32'(rresp[i]), 32'(e.resp));
`ifdef YSYX_IMEM_RAND_DELAY_EN
                chk({tag, "_lat_range"}, 32'((d >= lat_of(i)) && (d <= lat_of(i) + 7)), 32'd1);
                if ((d >= lat_of(i)) && (d <= lat_of(i) + 7)) hist[d - lat_of(i)]++;
`else
                chk({tag, "_lat"}, 32'(d), 32'(lat_of(i)));
`endif
            end
            arvalid[i] = 1'b0;
            araddr[i]  = scramble;
            ld_valid   = 1'b0;
        end
        chk({tag, "_timeout"}, 32'(seen), 32'd1);
        @(negedge clk);
        chk({tag, "_strobe_end"}, 32'(rvalid[i]), 32'd0);
        chk({tag, "_idle"}, 32'(arready[i]), 32'd1);
    endtask

    initial begin
        arvalid  = '0;
        araddr   = '0;
        ld_valid = 1'b0;
        ld_idx   = '0;
        ld_data  = '0;
        for (int k = 0; k < 8; k++) hist[k] = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_arready", 32'(arready[0]), 32'd1);
        chk("rst_rvalid", 32'(rvalid[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_rresp", 32'(rresp[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", 32'(arready), 32'h7);

`ifdef YSYX_IMEM_RAND_DELAY_EN
        for (int k = 0; k < 8; k++) preload(k, 32'hC0DE_0000 + 32'(k));
        for (int n = 0; n < 1000; n++) begin
            req(0, BASE + 32'(4 * $urandom_range(0, 7)));
            wait_resp(0, "rand", BASE);
        end
        for (int k = 0; k < 8; k++) chk($sformatf("rand_hist%0d", k), 32'(hist[k] > 0), 32'd1);
`else
        preload(0, 32'h0000_0413);
        preload(1, 32'hA1B2_C3D4);
        preload(2, 32'h0BAD_F00D);
        preload(4095, 32'hCAFE_F00D);

        req(0, BASE);
        wait_resp(0, "lat1_word0", BASE);

        // Preload to index 2 on the same edge that reads it: old word first, then new.
        issue(0, BASE + 32'h8, 1'b1, 2, 32'h1234_5678);
        wait_resp(0, "rbw_old", BASE);
        req(0, BASE + 32'h8);
        wait_resp(0, "rbw_new", BASE);

        req(1, BASE + 32'h4);
        wait_resp(1, "lat4_latched", BASE + 32'h8);

        req(1, BASE + 32'h2);
        wait_resp(1, "fault_misalign", BASE);
        req(1, BASE + 32'h3FFC);
        wait_resp(1, "last_word", BASE);
        req(0, 32'h7FFF_FFFC);
        wait_resp(0, "fault_below", BASE);
        req(1, BASE + 32'h4000);
        wait_resp(1, "fault_above", BASE);

        // arvalid held high at LATENCY=1: accept, respond, accept, ...
        @(negedge clk);
        arvalid[0] = 1'b1;
        araddr[0]  = BASE;
        for (int n = 0; n < 4; n++) begin
            exp_t e;
            e.inst = 0;
            e.t    = cyc + 2 * n;
            predict(BASE, e.data, e.resp);
            sb.push_back(e);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("b2b_rvalid", 32'(rvalid[0]), 32'(k % 2 == 1));
            chk("b2b_arready", 32'(arready[0]), 32'(k % 2 == 0));
            if (rvalid[0] && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("b2b_data", rdata[0], e.data);
                chk("b2b_lat", 32'(cyc - e.t), 32'd1);
            end
        end
        arvalid[0] = 1'b0;
        chk("b2b_all_popped", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a LATENCY=8 wait.
        req(2, BASE + 32'h4);
        @(negedge clk);
        arvalid[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pre_wait", 32'(arready[2]), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_rvalid", 32'(rvalid[2]), 32'd0);
        chk("rst_mid_arready", 32'(arready[2]), 32'd1);
        chk("rst_mid_rdata", rdata[0], 32'd0);
        chk("rst_mid_rresp", 32'(rresp[1]), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        begin
            bit stale;
            stale = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                stale = stale | rvalid[2];
            end
            chk("rst_no_stale", 32'(stale), 32'd0);
        end
        chk("rst_release_arready", 32'(arready[2]), 32'd1);

        req(0, BASE);
        wait_resp(0, "mem_kept", BASE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
